// File: rtl/pd_tap_sequencer_pkg.sv
// Shared constants for the predistorter tap sequencer: settings-bus register
// offsets, CTRL bit positions and FSM state encodings.
package pd_tap_sequencer_pkg;

  // Register offsets relative to SR_BASE
  localparam int unsigned RegTapAddr = 0;
  localparam int unsigned RegTapData = 1;
  localparam int unsigned RegCtrl    = 2;

  // CTRL register bits
  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlBankBit   = 1;
  localparam int unsigned CtrlClrErrBit = 2;

  // TAP_ADDR bit selecting the write bank
  localparam int unsigned TapAddrBankBit = 31;

  // FSM state encoding (plain constants for compatibility with older tools)
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StPrime  = 2'd1;
  localparam state_t StStream = 2'd2;

endpackage

// File: rtl/pd_tap_sequencer_if.sv
// AXI-stream style tap port from the sequencer to the predistorter.
interface pd_tap_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] taps_tdata;
  logic             taps_tvalid;
  logic             taps_tlast;
  logic             taps_tready;

  modport master (
    output taps_tdata,
    output taps_tvalid,
    output taps_tlast,
    input  taps_tready
  );

  modport slave (
    input  taps_tdata,
    input  taps_tvalid,
    input  taps_tlast,
    output taps_tready
  );
endinterface

// File: rtl/pd_tap_ram.sv
// Dual-bank tap RAM: one write port, one registered read port and, when
// PD_TAP_READBACK_EN is defined, a second registered read port for readback.
// Memory contents are not reset; only the read data registers are.
module pd_tap_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [DEPTH:0]   waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [DEPTH:0]   raddr_i,
  output logic [WIDTH-1:0] rdata_o
`ifdef PD_TAP_READBACK_EN
  ,
  input  logic [DEPTH:0]   rb_addr_i,
  output logic [WIDTH-1:0] rb_data_o
`endif
);

  localparam int unsigned Entries = 2 ** (DEPTH + 1);

  logic [WIDTH-1:0] mem_q [Entries];
  logic [WIDTH-1:0] rdata_q;

  // Write port; the bank is the MSB of the address
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Stream read port: holds its value when not enabled so backpressure keeps data stable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

`ifdef PD_TAP_READBACK_EN
  logic [WIDTH-1:0] rb_data_q;

  // Readback port tracks the write pointer every cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rb_data_q <= '0;
    end else begin
      rb_data_q <= mem_q[rb_addr_i];
    end
  end

  assign rb_data_o = rb_data_q;
`endif

endmodule

// File: rtl/pd_tap_sequencer.sv
// Predistorter tap sequencer: taps are written into one of two banks over the
// settings bus and streamed out of a selected bank on start.
// Optional feature: define PD_TAP_READBACK_EN to return the tap at the write
// pointer in rb_data[31:16].
module pd_tap_sequencer
  import pd_tap_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 7,
  parameter int unsigned SR_BASE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  pd_tap_sequencer_if.master        taps,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      active_bank,
  output logic [31:0]               rb_data
);

  localparam logic [7:0] AddrTapAddr = 8'(SR_BASE + RegTapAddr);
  localparam logic [7:0] AddrTapData = 8'(SR_BASE + RegTapData);
  localparam logic [7:0] AddrCtrl    = 8'(SR_BASE + RegCtrl);

  state_t           state_q, state_d;
  logic [DEPTH-1:0] beat_q, beat_d;
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic             wr_bank_q, wr_bank_d;
  logic             active_bank_q, active_bank_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             sel_tap_addr, sel_tap_data, sel_ctrl;
  logic             start_req, busy_int, tap_blocked, ram_we;
  logic             stream_valid, handshake, last_beat;
  logic             ram_re;
  logic [DEPTH-1:0] rd_ptr;
  logic [WIDTH-1:0] ram_rdata;
  logic             unused_set_data;

  assign unused_set_data = ^set_data;

  // Settings-bus decode and stream status
  always_comb begin
    sel_tap_addr = set_stb && (set_addr == AddrTapAddr);
    sel_tap_data = set_stb && (set_addr == AddrTapData);
    sel_ctrl     = set_stb && (set_addr == AddrCtrl);
    start_req    = sel_ctrl && set_data[CtrlStartBit];
    busy_int     = (state_q != StIdle);
    // Writes into the bank being streamed would corrupt the output
    tap_blocked  = busy_int && (wr_bank_q == active_bank_q);
    ram_we       = sel_tap_data && !tap_blocked;
    stream_valid = (state_q == StStream);
    handshake    = stream_valid && taps.taps_tready;
    last_beat    = (beat_q == {DEPTH{1'b1}});
  end

  // FSM next state; clear overrides everything and suppresses done
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    active_bank_d = active_bank_q;
    done_d        = 1'b0;
    if (clear) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_req) begin
            state_d       = StPrime;
            beat_d        = '0;
            active_bank_d = set_data[CtrlBankBit];
          end
        end
        StPrime: state_d = StStream;
        StStream: begin
          if (handshake) begin
            if (last_beat) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Read one tap ahead: tap 0 during PRIME, tap k+1 on the handshake of tap k
  always_comb begin
    rd_ptr = (state_q == StPrime) ? '0 : beat_q + 1'b1;
    ram_re = (state_q == StPrime) || (handshake && !last_beat);
  end

  // Write pointer; a dropped write leaves the pointer where it was
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    if (sel_tap_addr) begin
      wr_ptr_d  = set_data[DEPTH-1:0];
      wr_bank_d = set_data[TapAddrBankBit];
    end else if (ram_we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // Sticky error: clear bit is applied first so a combined clear+start re-flags when busy
  always_comb begin
    err_d = err_q;
    if (sel_ctrl && set_data[CtrlClrErrBit]) begin
      err_d = 1'b0;
    end
    if ((start_req && busy_int) || (sel_tap_data && tap_blocked)) begin
      err_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      active_bank_q <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      active_bank_q <= active_bank_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

`ifdef PD_TAP_READBACK_EN
  logic [WIDTH-1:0] rb_tap;
`endif

  pd_tap_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (reset),
    .we_i      (ram_we),
    .waddr_i   ({wr_bank_q, wr_ptr_q}),
    .wdata_i   (set_data[WIDTH-1:0]),
    .re_i      (ram_re),
    .raddr_i   ({active_bank_q, rd_ptr}),
    .rdata_o   (ram_rdata)
`ifdef PD_TAP_READBACK_EN
    ,
    .rb_addr_i ({wr_bank_q, wr_ptr_q}),
    .rb_data_o (rb_tap)
`endif
  );

  // Outputs
  always_comb begin
    taps.taps_tdata  = ram_rdata;
    taps.taps_tvalid = stream_valid;
    taps.taps_tlast  = stream_valid && last_beat;
    busy             = busy_int;
    done             = done_q;
    err              = err_q;
    active_bank      = active_bank_q;
`ifdef PD_TAP_READBACK_EN
    rb_data = {16'(rb_tap), 12'b0, err_q, active_bank_q, busy_int, state_q == StIdle};
`else
    rb_data = {16'b0, 12'b0, err_q, active_bank_q, busy_int, state_q == StIdle};
`endif
  end

endmodule

// File: tb/tb_pd_tap_sequencer.sv
// Directed bench for pd_tap_sequencer: loads both banks, streams with and
// without backpressure, and exercises error, clear, reset and readback paths.
module tb_pd_tap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        busy, done, err, active_bank;
  logic [31:0] rb_data;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] mdl [2][128];

  pd_tap_sequencer_if #(.WIDTH(16)) tif ();

  pd_tap_sequencer #(
    .WIDTH   (16),
    .DEPTH   (7),
    .SR_BASE (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .taps        (tif),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .active_bank (active_bank),
    .rb_data     (rb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One settings-bus write; returns at the negedge after the write edge
  task automatic sr_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    @(negedge clk);
    set_stb  = 1'b0;
  endtask

  // Called one cycle after the start strobe; iteration c is cycle N+1+c
  task automatic stream_check(input int bank, input bit toggle, input int exp_done);
    int          beats = 0;
    int          cyc = 0;
    int          done_at = 0;
    int          first_valid = 0;
    bit          hold_pend = 0;
    logic [15:0] hold_d = '0;
    logic        hold_l = 1'b0;
    while (done_at == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hold_pend) begin
        chk("hold_valid", 32'(tif.taps_tvalid), 32'd1);
        chk("hold_data", 32'(tif.taps_tdata), 32'(hold_d));
        chk("hold_last", 32'(tif.taps_tlast), 32'(hold_l));
      end
      hold_pend = 0;
      tif.taps_tready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (tif.taps_tvalid) begin
        if (first_valid == 0) first_valid = cyc;
        if (tif.taps_tready) begin
          if (beats < 128) begin
            chk("beat_data", 32'(tif.taps_tdata), 32'(mdl[bank][beats]));
            chk("beat_last", 32'(tif.taps_tlast), 32'(beats == 127));
          end else begin
            chk("extra_beat", 32'(beats), 32'd127);
          end
          beats++;
        end else begin
          hold_pend = 1;
          hold_d    = tif.taps_tdata;
          hold_l    = tif.taps_tlast;
        end
      end
      if (done) done_at = cyc;
    end
    chk("first_valid", 32'(first_valid), 32'd1);
    chk("beat_count", 32'(beats), 32'd128);
    chk("done_cycle", 32'(done_at), 32'(exp_done));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(tif.taps_tvalid), 32'd0);
  endtask

  initial begin
    int guard;
    reset           = 1'b0;
    clear           = 1'b0;
    set_stb         = 1'b0;
    set_addr        = '0;
    set_data        = '0;
    tif.taps_tready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", 32'(tif.taps_tvalid), 32'd0);
    chk("rst_last", 32'(tif.taps_tlast), 32'd0);
    chk("rst_data", 32'(tif.taps_tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bank", 32'(active_bank), 32'd0);
    chk("rst_rb", rb_data, 32'h0000_0001);
    reset = 1'b1;

    // Load bank 0 with 0..127, bank 1 with 0x1000+i, then one wrapped write
    sr_write(8'd0, 32'h0);
    for (int i = 0; i < 128; i++) begin
      sr_write(8'd1, 32'(i));
      mdl[0][i] = 16'(i);
    end
    sr_write(8'd0, 32'h8000_0000);
    for (int i = 0; i < 128; i++) begin
      sr_write(8'd1, 32'h1000 + 32'(i));
      mdl[1][i] = 16'h1000 + 16'(i);
    end
    sr_write(8'd1, 32'h2000);
    mdl[1][0] = 16'h2000;
    chk("load_err", 32'(err), 32'd0);

    // Readback of bank 1 tap 3
    sr_write(8'd0, 32'h8000_0003);
    @(negedge clk);
`ifdef PD_TAP_READBACK_EN
    chk("rb_tap", 32'(rb_data[31:16]), 32'h1003);
`else
    chk("rb_zero", 32'(rb_data[31:16]), 32'h0);
`endif

    // Full-rate stream of bank 0
    sr_write(8'd2, 32'h1);
    chk("prime_valid", 32'(tif.taps_tvalid), 32'd0);
    chk("prime_busy", 32'(busy), 32'd1);
    chk("prime_rb", rb_data & 32'hF, 32'h2);
    stream_check(0, 1'b0, 129);

    // Backpressured stream, tready toggling
    sr_write(8'd2, 32'h1);
    stream_check(0, 1'b1, 256);

    // Start while busy, err clear, and writes to both banks during a bank-0 stream
    sr_write(8'd2, 32'h1);
    fork
      stream_check(0, 1'b0, 129);
      begin
        repeat (5) @(negedge clk);
        sr_write(8'd2, 32'h3);
        chk("busy_start_err", 32'(err), 32'd1);
        chk("busy_start_bank", 32'(active_bank), 32'd0);
        sr_write(8'd2, 32'h4);
        chk("ctrl_clr_err", 32'(err), 32'd0);
        sr_write(8'd0, 32'h8000_0005);
        sr_write(8'd1, 32'hBEEF);
        chk("other_bank_err", 32'(err), 32'd0);
        sr_write(8'd0, 32'h0000_0005);
        sr_write(8'd1, 32'h1234);
        chk("active_bank_err", 32'(err), 32'd1);
      end
    join
    mdl[1][5] = 16'hBEEF;

    // Combined clear-err + start of bank 1 while idle with err set
    sr_write(8'd2, 32'h7);
    chk("clr_start_err", 32'(err), 32'd0);
    chk("clr_start_bank", 32'(active_bank), 32'd1);
    chk("clr_start_rb", rb_data & 32'hF, 32'h6);
    stream_check(1, 1'b0, 129);

    // Clear at beat 40
    sr_write(8'd2, 32'h1);
    guard = 0;
    tif.taps_tready = 1'b1;
    while (guard < 200) begin
      @(negedge clk);
      guard++;
      if (tif.taps_tvalid && tif.taps_tdata == 16'd40) break;
    end
    chk("clear_reach40", 32'(tif.taps_tdata), 32'd40);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_valid", 32'(tif.taps_tvalid), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_done", 32'(done), 32'd0);
    chk("clear_last", 32'(tif.taps_tlast), 32'd0);
    @(negedge clk);
    chk("clear_done2", 32'(done), 32'd0);
    // Restart streams from tap 0; bank 0 addr 5 must be untouched
    sr_write(8'd2, 32'h1);
    stream_check(0, 1'b0, 129);

    // Reset mid-stream with err set
    sr_write(8'd2, 32'h1);
    repeat (10) @(negedge clk);
    sr_write(8'd2, 32'h1);
    chk("pre_rst_err", 32'(err), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tif.taps_tvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_rb", rb_data & 32'hFFFF, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    // Pointer reset to bank 0 addr 0
    sr_write(8'd1, 32'h00AA);
    mdl[0][0] = 16'h00AA;
    sr_write(8'd2, 32'h1);
    stream_check(0, 1'b0, 129);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
